muldiv_iter: RTL and testbench

Iterative RV32M multiply/divide unit sitting directly downstream of the ALU operand-B select: it consumes operand A (rs1) and the selected operand B and produces one 32-bit M-extension result after a fixed multi-cycle latency. The core stalls on `busy` and writes `result` back when `done` pulses. One multiplier/divider datapath is shared by all eight M-extension operations, using shift-add for multiply and restoring division for divide.

---
 rtl/muldiv_iter.sv | 143 ++++++++++++++
 tb/tb_muldiv_iter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: one shared datapath runs shift-add
// multiply and restoring divide with a fixed 34-cycle latency.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned AW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            sa, sb, div0, ovf;
  logic [AW-1:0]   acc;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] orig_a;

  logic            sa_c, sb_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c;
  logic [XLEN:0]   mul_sum_c;
  logic            div_ge_c;
  logic [XLEN-1:0] div_sub_c;
  logic [AW-1:0]   step_c, prod_c;
  logic [XLEN-1:0] quo_c, rem_c, fix_c;

  // Operand sign handling at capture time
  always_comb begin
    sa_c    = opa[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) |
                             (op == OP_DIV)  | (op == OP_REM));
    sb_c    = opb[XLEN-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
    abs_a_c = sa_c ? (~opa + XLEN'(1)) : opa;
    abs_b_c = sb_c ? (~opb + XLEN'(1)) : opb;
  end

  // One iteration: acc holds {hi, lo}; lo starts as |opa| (multiplier or dividend)
  always_comb begin
    mul_sum_c = {1'b0, acc[AW-1:XLEN]} + {1'b0, (acc[0] ? mag_b : {XLEN{1'b0}})};
    div_ge_c  = acc[AW-1:XLEN-1] >= {1'b0, mag_b};
    div_sub_c = acc[AW-2:XLEN-1] - mag_b;
    if (op_q[2]) begin
      if (div_ge_c) step_c = {div_sub_c, acc[XLEN-2:0], 1'b1};
      else          step_c = {acc[AW-2:0], 1'b0};
    end else begin
      step_c = {mul_sum_c, acc[XLEN-1:1]};
    end
  end

  // Sign fix-up and output select, with div-by-zero / overflow overrides
  always_comb begin
    prod_c = (sa ^ sb) ? (~acc + AW'(1)) : acc;
    quo_c  = (sa ^ sb) ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem_c  = sa ? (~acc[AW-1:XLEN] + XLEN'(1)) : acc[AW-1:XLEN];
    fix_c  = {XLEN{1'b0}};
    case (op_q)
      OP_MUL:                      fix_c = prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_c = prod_c[AW-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div0)     fix_c = {XLEN{1'b1}};
        else if (ovf) fix_c = MIN_NEG;
        else          fix_c = quo_c;
      end
      default: begin
        if (div0)     fix_c = orig_a;
        else if (ovf) fix_c = {XLEN{1'b0}};
        else          fix_c = rem_c;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      acc    <= '0;
      mag_b  <= '0;
      orig_a <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sa     <= sa_c;
            sb     <= sb_c;
            div0   <= (opb == {XLEN{1'b0}});
            ovf    <= op[2] & ~op[0] & (opa == MIN_NEG) & (opb == {XLEN{1'b1}});
            acc    <= {{XLEN{1'b0}}, abs_a_c};
            mag_b  <= abs_b_c;
            orig_a <= opa;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= step_c;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          result <= fix_c;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: result values, fixed latency, handshake and reset abort.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after accept, check latency, result and return to idle
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    start = 1'b1; op = o; opa = a; opb = b;
    tick();
    start = 1'b0; op = 3'($urandom); opa = $urandom; opb = $urandom;
    check({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n + 1), 32'd34);
    check(tag, result, exp);
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    tick();
    check("idle busy", 32'(busy), 32'd0);

    run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("MUL low",         3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    run_op("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
    run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
    run_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14);
    run_op("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2);
    run_op("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF);
    run_op("REMU 5/0",        3'b111, 32'd5,        32'd0,        32'd5);
    run_op("DIVU 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF);
    run_op("REM -5/0",        3'b110, 32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB);
    run_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // start held high: only the first op runs; the next one starts after busy drops
    start = 1'b1; op = 3'b000; opa = 32'd3; opb = 32'd5;
    tick();
    check("hold accept busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom); opa = $urandom; opb = $urandom;
      tick();
    end
    op = 3'b101; opa = 32'd100; opb = 32'd7;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("hold first done", 32'(done), 32'd1);
    check("hold first result", result, 32'd15);
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    check("hold busy drop", 32'(busy), 32'd0);
    tick();
    check("hold second accept", 32'(busy), 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("hold second done", 32'(done), 32'd1);
    check("hold second result", result, 32'd14);
    tick();

    // reset part-way through a DIVU aborts it without a done pulse
    start = 1'b1; op = 3'b101; opa = 32'd1000; opb = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n++;
    end
    check("abort no done", 32'(n), 32'd0);
    check("abort result held", result, 32'd0);
    run_op("MUL 3*4 after reset", 3'b000, 32'd3, 32'd4, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
